// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI XIP read sequencer: slave register map,
// status bits, command codes, data-phase modes and sequencer/APB states.
package qspi_pkg;

    localparam logic [4:0] REG_CFG   = 5'h00;
    localparam logic [4:0] REG_DATA  = 5'h04;
    localparam logic [4:0] REG_STAT  = 5'h08;
    localparam logic [4:0] REG_CMD   = 5'h14;
    localparam logic [4:0] REG_CSCFG = 5'h18;

    localparam int STAT_RX_NEMPTY = 5;
    localparam int STAT_CMD_IDLE  = 7;

    localparam logic [3:0] CMD_DUMMY = 4'h0;
    localparam logic [3:0] CMD_WR_S  = 4'h1;
    localparam logic [3:0] CMD_RD_S  = 4'h2;
    localparam logic [3:0] CMD_WR_D  = 4'h4;
    localparam logic [3:0] CMD_RD_D  = 4'h5;
    localparam logic [3:0] CMD_WR_Q  = 4'h6;
    localparam logic [3:0] CMD_RD_Q  = 4'h7;
    localparam logic [3:0] CMD_CS    = 4'hF;

    typedef enum logic [1:0] {
        MODE_SPI = 2'd0,
        MODE_DPI = 2'd1,
        MODE_QPI = 2'd2
    } mode_e;

    typedef enum logic [3:0] {
        S_IDLE, S_CS_ON, S_TX_PUSH, S_CMD_ADDR, S_CMD_DUMMY, S_CMD_RD,
        S_POLL, S_POP, S_OUT, S_CS_OFF, S_WAIT_IDLE, S_FIN
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE, PH_SETUP, PH_ACCESS
    } apb_phase_e;

    typedef struct packed {
        logic        valid;
        logic [4:0]  addr;
        logic        we;
        logic [31:0] wdata;
    } apb_req_t;

    function automatic logic [31:0] cmd_word(input logic [3:0] cmd, input logic [7:0] arg);
        return {20'h0, cmd, arg};
    endfunction

    function automatic logic [3:0] rd_cmd(input mode_e m);
        case (m)
            MODE_DPI: return CMD_RD_D;
            MODE_QPI: return CMD_RD_Q;
            default:  return CMD_RD_S;
        endcase
    endfunction

endpackage

// File: rtl/qspi_apb_master.sv
// Single-transfer APB master; a start on the completing cycle chains the
// next setup phase with no idle cycle in between.
module qspi_apb_master
    import qspi_pkg::*;
(
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        start,
    input  logic [4:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic [4:0]  PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    apb_phase_e ph_q, ph_d;
    logic       load;

    assign busy    = (ph_q != PH_IDLE);
    assign ack     = (ph_q == PH_ACCESS) && PREADY;
    assign rdata   = PRDATA;
    assign PSEL    = busy;
    assign PENABLE = (ph_q == PH_ACCESS);

    always_comb begin
        ph_d = ph_q;
        load = 1'b0;
        case (ph_q)
            PH_IDLE: if (start) begin
                ph_d = PH_SETUP;
                load = 1'b1;
            end
            PH_SETUP: ph_d = PH_ACCESS;
            PH_ACCESS: if (PREADY) begin
                ph_d = start ? PH_SETUP : PH_IDLE;
                load = start;
            end
            default: ph_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ph_q   <= PH_IDLE;
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else begin
            ph_q <= ph_d;
            if (load) begin
                PADDR  <= addr;
                PWRITE <= we;
                PWDATA <= wdata;
            end
        end
    end

endmodule

// File: rtl/qspi_xip_rd_seq.sv
// Flash read sequencer: drives one read request through the QSPI slave's
// command-mode register interface and streams the returned words out.
module qspi_xip_rd_seq
    import qspi_pkg::*;
#(
    parameter int CS_IDX    = 0,
    parameter int DUMMY_CYC = 8,
    parameter int POLL_TMO  = 1023
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_opcode,
    input  logic [1:0]  req_mode,
    input  logic [5:0]  req_nwords,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        err,
    output logic [4:0]  PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    state_e      state_q, state_d;
    logic [23:0] addr_q;
    logic [7:0]  opcode_q;
    mode_e       mode_q;
    logic [5:0]  nwords_q, cnt_q;
    logic [9:0]  poll_q;
    logic        err_q;
    logic [31:0] rd_data_q;

    logic        start, busy, ack, poll_tmo;
    logic [31:0] rdata;
    apb_req_t    cur_req, nxt_req, launch_req;

    function automatic apb_req_t req_for(input state_e st, input logic [7:0] op,
                                         input logic [23:0] a, input mode_e m,
                                         input logic [5:0] nw);
        apb_req_t r;
        r = '0;
        r.valid = 1'b1;
        case (st)
            S_CS_ON:     begin r.addr = REG_CMD;  r.we = 1'b1; r.wdata = cmd_word(CMD_CS, ~(8'd1 << CS_IDX)); end
            S_TX_PUSH:   begin r.addr = REG_DATA; r.we = 1'b1; r.wdata = {op, a}; end
            S_CMD_ADDR:  begin r.addr = REG_CMD;  r.we = 1'b1; r.wdata = cmd_word(CMD_WR_S, 8'd3); end
            S_CMD_DUMMY: begin r.addr = REG_CMD;  r.we = 1'b1; r.wdata = cmd_word(CMD_DUMMY, 8'(DUMMY_CYC)); end
            // Byte count minus one: 4*(nw+1)-1 is nw with two low ones appended.
            S_CMD_RD:    begin r.addr = REG_CMD;  r.we = 1'b1; r.wdata = cmd_word(rd_cmd(m), {nw, 2'b11}); end
            S_POLL,
            S_WAIT_IDLE: r.addr = REG_STAT;
            S_POP:       r.addr = REG_DATA;
            S_CS_OFF:    begin r.addr = REG_CMD;  r.we = 1'b1; r.wdata = cmd_word(CMD_CS, 8'hFF); end
            default:     r.valid = 1'b0;
        endcase
        return r;
    endfunction

    assign poll_tmo  = (poll_q == 10'(POLL_TMO));
    assign req_ready = (state_q == S_IDLE);
    assign rd_valid  = (state_q == S_OUT);
    assign rd_data   = rd_data_q;
    assign done      = (state_q == S_FIN);
    assign err       = done && err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (req_valid) state_d = S_CS_ON;
            S_CS_ON:     if (ack) state_d = S_TX_PUSH;
            S_TX_PUSH:   if (ack) state_d = S_CMD_ADDR;
            S_CMD_ADDR:  if (ack) state_d = (DUMMY_CYC == 0) ? S_CMD_RD : S_CMD_DUMMY;
            S_CMD_DUMMY: if (ack) state_d = S_CMD_RD;
            S_CMD_RD:    if (ack) state_d = S_POLL;
            S_POLL: if (ack) begin
                if (rdata[STAT_RX_NEMPTY]) state_d = S_POP;
                else if (poll_tmo)         state_d = S_CS_OFF;
            end
            S_POP:       if (ack) state_d = S_OUT;
            S_OUT:       if (rd_ready) state_d = (cnt_q == nwords_q) ? S_CS_OFF : S_POLL;
            S_CS_OFF:    if (ack) state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: if (ack && (rdata[STAT_CMD_IDLE] || poll_tmo)) state_d = S_FIN;
            S_FIN:       state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // On the completing cycle the next state's transfer is launched at once,
    // so consecutive transfers run back-to-back.
    assign cur_req = req_for(state_q, opcode_q, addr_q, mode_q, nwords_q);
    assign nxt_req = req_for(state_d, opcode_q, addr_q, mode_q, nwords_q);

    always_comb begin
        launch_req = ack ? nxt_req : cur_req;
        start      = ack ? nxt_req.valid : (!busy && cur_req.valid);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            opcode_q  <= '0;
            mode_q    <= MODE_SPI;
            nwords_q  <= '0;
            cnt_q     <= '0;
            poll_q    <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid) begin
                addr_q   <= req_addr;
                opcode_q <= req_opcode;
                mode_q   <= (req_mode == 2'd3) ? MODE_SPI : mode_e'(req_mode);
                nwords_q <= req_nwords;
                cnt_q    <= '0;
                err_q    <= 1'b0;
            end
            if (state_d != state_q && (state_d == S_POLL || state_d == S_WAIT_IDLE))
                poll_q <= '0;
            else if (ack && (state_q == S_POLL || state_q == S_WAIT_IDLE))
                poll_q <= poll_q + 10'd1;
            if (ack && poll_tmo &&
                ((state_q == S_POLL && !rdata[STAT_RX_NEMPTY]) ||
                 (state_q == S_WAIT_IDLE && !rdata[STAT_CMD_IDLE])))
                err_q <= 1'b1;
            if (state_q == S_OUT && rd_ready && cnt_q != nwords_q)
                cnt_q <= cnt_q + 6'd1;
            if (state_q == S_POP && ack)
                rd_data_q <= rdata;
        end
    end

    qspi_apb_master u_apb (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .start   (start),
        .addr    (launch_req.addr),
        .we      (launch_req.we),
        .wdata   (launch_req.wdata),
        .busy    (busy),
        .ack     (ack),
        .rdata   (rdata),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

endmodule

// File: tb/tb_qspi_xip_rd_seq.sv
// Directed bench for qspi_xip_rd_seq with an APB slave model and
// scoreboards for APB writes and returned read words.
module tb_qspi_xip_rd_seq;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        req_valid, req_ready;
    logic [23:0] req_addr;
    logic [7:0]  req_opcode;
    logic [1:0]  req_mode;
    logic [5:0]  req_nwords;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        done, err;
    logic [4:0]  PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY;

    always #5 PCLK = ~PCLK;

    qspi_xip_rd_seq #(.CS_IDX(0), .DUMMY_CYC(8), .POLL_TMO(15)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_opcode(req_opcode), .req_mode(req_mode), .req_nwords(req_nwords),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- APB slave model ----------------
    int          ws = 0;
    int          rx_after = 2;
    int          acc_cnt;
    int          poll_cnt = 0;
    logic [31:0] pop_idx = 32'd0;
    logic [31:0] stat_word;

    assign stat_word = {24'h0, 1'b1, 1'b0, (poll_cnt >= rx_after), 5'h0};
    assign PREADY    = PSEL && PENABLE && (acc_cnt >= ws);
    assign PRDATA    = (PADDR == 5'h08) ? stat_word :
                       (PADDR == 5'h04) ? (32'hC0DE0000 + pop_idx * 32'h00010003) : 32'h0;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) acc_cnt <= 0;
        else if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always @(posedge PCLK) begin
        if (PRESETn && PSEL && PENABLE && PREADY) begin
            if (!PWRITE && PADDR == 5'h04) begin
                pop_idx  <= pop_idx + 32'd1;
                poll_cnt <= 0;
            end else if (!PWRITE && PADDR == 5'h08) begin
                poll_cnt <= poll_cnt + 1;
            end else if (PWRITE && PADDR == 5'h14 && PWDATA == 32'h0000_0FFE) begin
                poll_cnt <= 0;
            end
        end
    end

    // ---------------- scoreboards and monitors ----------------
    logic [36:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    int          done_cnt = 0;
    logic        last_err = 1'b0;
    int          beat_cnt = 0;
    int          n_stat = 0;
    int          stat_before_csoff = -1;

    logic        p_valid = 1'b0;
    logic        p_sel, p_en, p_rdy, p_wr, p_rdv, p_rdr;
    logic [4:0]  p_addr;
    logic [31:0] p_wd, p_rdd;

    task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic push_seq(input logic [7:0] op, input logic [23:0] a,
                            input logic [1:0] mode, input logic [5:0] nw);
        logic [3:0] rdc;
        rdc = (mode == 2'd1) ? 4'h5 : (mode == 2'd2) ? 4'h7 : 4'h2;
        push_wr(5'h14, 32'h0000_0FFE);
        push_wr(5'h04, {op, a});
        push_wr(5'h14, 32'h0000_0103);
        push_wr(5'h14, 32'h0000_0008);
        push_wr(5'h14, {20'h0, rdc, nw, 2'b11});
        push_wr(5'h14, 32'h0000_0FFF);
    endtask

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            p_valid = 1'b0;
        end else begin
            if (p_valid && p_sel && !p_en)
                check("apb_setup_to_access", {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                      {2'b11, p_wr, p_addr, p_wd});
            if (p_valid && p_sel && p_en && !p_rdy)
                check("apb_wait_hold", {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                      {2'b11, p_wr, p_addr, p_wd});
            if (p_valid && p_sel && p_en && p_rdy)
                check("apb_enable_drop", PENABLE, 1'b0);
            if (PSEL && PENABLE && PREADY) begin
                if (PWRITE) begin
                    if (PADDR == 5'h14 && PWDATA == 32'h0000_0FFE) n_stat = 0;
                    if (PADDR == 5'h14 && PWDATA == 32'h0000_0FFF) stat_before_csoff = n_stat;
                    if (exp_wr.size() == 0) begin
                        checks++;
                        failures++;
                        $error("FAIL apb_write_unexpected observed=%0h expected=none", {PADDR, PWDATA});
                    end else begin
                        check("apb_write", {PADDR, PWDATA}, exp_wr.pop_front());
                    end
                end else if (PADDR == 5'h08) begin
                    n_stat++;
                end else if (PADDR == 5'h04) begin
                    exp_rd.push_back(PRDATA);
                end
            end
            if (done) begin
                done_cnt++;
                last_err = err;
            end
            if (err) check("err_with_done", done, 1'b1);
            if (rd_valid) begin
                check("no_apb_in_out", PSEL, 1'b0);
                if (p_valid && p_rdv && !p_rdr) check("rd_data_stable", rd_data, p_rdd);
                if (rd_ready) begin
                    beat_cnt++;
                    if (exp_rd.size() == 0) begin
                        checks++;
                        failures++;
                        $error("FAIL rd_unexpected observed=%0h expected=none", rd_data);
                    end else begin
                        check("rd_data", rd_data, exp_rd.pop_front());
                    end
                end
            end
            p_valid = 1'b1;
            p_sel = PSEL; p_en = PENABLE; p_rdy = PREADY; p_wr = PWRITE;
            p_addr = PADDR; p_wd = PWDATA;
            p_rdv = rd_valid; p_rdr = rd_ready; p_rdd = rd_data;
        end
    end

    // ---------------- consumer ----------------
    int stall_at = -1;
    int stall_left = 0;

    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge PCLK);
            #1;
            if (rd_valid && beat_cnt == stall_at && stall_left > 0) begin
                rd_ready = 1'b0;
                stall_left--;
            end else begin
                rd_ready = 1'b1;
            end
        end
    end

    // ---------------- directed steps ----------------
    task automatic send_req(input logic [23:0] a, input logic [7:0] op,
                            input logic [1:0] mode, input logic [5:0] nw);
        int n = 0;
        @(negedge PCLK);
        while (!req_ready && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        check("req_ready_idle", req_ready, 1'b1);
        req_addr = a; req_opcode = op; req_mode = mode; req_nwords = nw;
        req_valid = 1'b1;
        @(posedge PCLK);
        #1;
        req_valid = 1'b0;
        check("req_ready_busy", req_ready, 1'b0);
    endtask

    task automatic finish_req(input string tag, input int budget, input logic exp_err,
                              input int beats_exp, input int stat_exp, input int b0);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge PCLK);
            n++;
        end
        check({tag, "_done_seen"}, (done_cnt != d0), 1'b1);
        repeat (3) @(negedge PCLK);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_err"}, last_err, exp_err);
        check({tag, "_beats"}, beat_cnt - b0, beats_exp);
        check({tag, "_polls"}, stat_before_csoff, stat_exp);
        check({tag, "_wr_left"}, exp_wr.size(), 0);
        check({tag, "_rd_left"}, exp_rd.size(), 0);
    endtask

    initial begin
        int b0;
        int n;
        PRESETn = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_opcode = '0; req_mode = '0; req_nwords = '0;
        repeat (2) @(negedge PCLK);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_psel_penable", {PSEL, PENABLE}, 2'b00);
        check("rst_pwrite_paddr", {PWRITE, PADDR}, 6'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_done_err", {done, err}, 2'b00);
        PRESETn = 1'b1;

        // Basic SPI single word, status ready on the third poll.
        rx_after = 2; ws = 0;
        push_seq(8'h03, 24'h123456, 2'd0, 6'd0);
        b0 = beat_cnt;
        send_req(24'h123456, 8'h03, 2'd0, 6'd0);
        finish_req("spi1", 2000, 1'b0, 1, 3, b0);

        // QPI, 64 words.
        rx_after = 0;
        push_seq(8'h6B, 24'h000100, 2'd2, 6'd63);
        b0 = beat_cnt;
        send_req(24'h000100, 8'h6B, 2'd2, 6'd63);
        finish_req("qpi64", 5000, 1'b0, 64, 64, b0);

        // DPI, four words, consumer stalls 20 cycles on word index 2.
        rx_after = 1;
        push_seq(8'h3B, 24'hABCDEF, 2'd1, 6'd3);
        b0 = beat_cnt;
        stall_at = b0 + 2; stall_left = 20;
        send_req(24'hABCDEF, 8'h3B, 2'd1, 6'd3);
        finish_req("stall", 2000, 1'b0, 4, 8, b0);
        check("stall_applied", stall_left, 0);
        stall_at = -1;

        // Status never reports data: abort after POLL_TMO+1 polls.
        rx_after = 1000;
        push_seq(8'h03, 24'h000000, 2'd0, 6'd5);
        b0 = beat_cnt;
        send_req(24'h000000, 8'h03, 2'd0, 6'd5);
        finish_req("timeout", 2000, 1'b1, 0, 16, b0);

        // Same as the first request with three wait states per transfer; mode 3 acts as SPI.
        rx_after = 2; ws = 3;
        push_seq(8'h03, 24'h123456, 2'd0, 6'd0);
        b0 = beat_cnt;
        send_req(24'h123456, 8'h03, 2'd3, 6'd0);
        finish_req("waitst", 4000, 1'b0, 1, 3, b0);

        // Reset during the POP setup phase, then a fresh request.
        ws = 0; rx_after = 0;
        push_seq(8'h03, 24'h000010, 2'd0, 6'd3);
        send_req(24'h000010, 8'h03, 2'd0, 6'd3);
        n = 0;
        @(negedge PCLK);
        while (!(PSEL && !PENABLE && !PWRITE && PADDR == 5'h04) && n < 500) begin
            @(negedge PCLK);
            n++;
        end
        check("pop_reached", (n < 500), 1'b1);
        PRESETn = 1'b0;
        #1;
        check("midrst_psel", PSEL, 1'b0);
        @(negedge PCLK);
        check("midrst_next_psel", {PSEL, PENABLE}, 2'b00);
        check("midrst_req_ready", req_ready, 1'b1);
        check("midrst_rd_valid", rd_valid, 1'b0);
        exp_wr.delete();
        exp_rd.delete();
        @(negedge PCLK);
        PRESETn = 1'b1;
        push_seq(8'h0B, 24'h222222, 2'd0, 6'd1);
        b0 = beat_cnt;
        send_req(24'h222222, 8'h0B, 2'd0, 6'd1);
        finish_req("after_rst", 2000, 1'b0, 2, 2, b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qspi_xip_rd_seq.md
Name: qspi_xip_rd_seq

Overview:
- APB-master sequencer that turns one flash read request into the command-mode transaction stream for the tiny_qspi_apb slave.
- Sequence: chip-select on, opcode/address push, address write command, dummy, read command, RX drain, chip-select off.
- Returned words leave on a valid/ready stream.
- Sits between a cache/boot fetcher and the QSPI slave; it is the only APB master on that slave.

Parameters:
- CS_IDX, 0, MCS line (0-7) asserted for the flash.
- DUMMY_CYC, 8, dummy SCLK cycles between address and data.
- POLL_TMO, 1023, maximum status polls per wait before aborting with error.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  read request.
- req_ready  out  1  high only in IDLE.
- req_addr  in  24  flash byte address.
- req_opcode  in  8  flash read opcode (e.g. 0x03/0x3B/0x6B).
- req_mode  in  2  data phase width: 0 SPI, 1 DPI, 2 QPI; 3 is treated as 0.
- req_nwords  in  6  words to read minus one (1..64 words).
- rd_valid  out  1  read word valid.
- rd_ready  in  1  consumer ready.
- rd_data  out  32  read word.
- done  out  1  one-cycle pulse at end of request.
- err  out  1  one-cycle pulse, coincident with done, on poll timeout.
- PADDR  out  5  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Reset values: all outputs 0 except req_ready=1. State=IDLE. Any in-flight APB transfer is abandoned with no further phases; the slave is reset separately.
- Slave map used:
  - 0x04: TX push on write, RX pop on read.
  - 0x08: status. Bit5 RX not empty; bit7 command queue idle.
  - 0x14: command {20'h0, cmd[3:0], arg[7:0]}.
- APB transfers: setup phase one cycle (PSEL=1, PENABLE=0), then access phase held until PREADY=1. PSEL and PENABLE drop the cycle after completion. Back-to-back transfers insert no idle cycle. PRDATA is captured on the PREADY cycle.
- Handshake: req fields latched when req_valid & req_ready. Requests arriving outside IDLE are not accepted.
- FSM states, each one APB transfer unless noted:
  - IDLE
  - CS_ON: write 0x14 {cmd 0xF, arg ~(1<<CS_IDX)}.
  - TX_PUSH: write 0x04 {opcode, addr}.
  - CMD_ADDR: write 0x14 {0x1, 8'd3} (4 bytes, SPI).
  - CMD_DUMMY: write 0x14 {0x0, DUMMY_CYC}. Skipped when DUMMY_CYC=0.
  - CMD_RD: write 0x14 {rdcmd, 4*(nwords+1)-1}; rdcmd is 0x2/0x5/0x7 for SPI/DPI/QPI.
  - POLL: read 0x08; on bit5 go to POP, else repeat.
  - POP: read 0x04.
  - OUT: rd_valid=1 until rd_ready. Then if count==nwords go to CS_OFF, else count+1 and go to POLL.
  - CS_OFF: write 0x14 {0xF, 0xFF}.
  - WAIT_IDLE: read 0x08 until bit7.
  - FIN: done pulse, back to IDLE.
- Word counter is 6 bits; 64 words maps to arg 255 exactly. No wrap is possible.
- rd_data is stable while rd_valid & !rd_ready. No APB transfer is issued while in OUT (backpressure stalls the sequencer, not the slave).
- Timeout: a 10-bit poll counter clears on entering POLL or WAIT_IDLE. After POLL_TMO+1 unsuccessful polls, jump to CS_OFF with an error flag set. The remaining words are discarded (no rd_valid). WAIT_IDLE timeout goes directly to FIN. err pulses together with done.
- Latency with PREADY tied high and no stalls: 2 cycles per transfer.

Decomposition:
- Package qspi_pkg:
  - Slave register offsets (CFG 0x00, DATA 0x04, STAT 0x08, CMD 0x14, CSCFG 0x18).
  - Status bit indices.
  - Command codes (DUMMY 0x0, WR_S 0x1, RD_S 0x2, WR_D 0x4, RD_D 0x5, WR_Q 0x6, RD_Q 0x7, CS 0xF).
  - Mode enum.
  - FSM state enum.
- Sub-module qspi_apb_master: single-transfer engine.
  - Inputs start, addr, we, wdata.
  - Outputs busy, ack (one cycle), rdata.
  - Drives the APB pins.

Test Plan:
- Request addr 0x123456, opcode 0x03, SPI, nwords 0, DUMMY_CYC 8; slave model returns status bit5 on the 3rd poll -> APB writes in order 0x14←0xF_FE, 0x04←0x03123456, 0x14←0x1_03, 0x14←0x0_08, 0x14←0x2_03. One rd_valid word equals the model's popped data. 0x14←0xF_FF, then done=1, err=0.
- QPI request, nwords 63 -> CMD_RD writes 0x14←0x7_FF. Exactly 64 rd_valid beats in FIFO order, then done.
- rd_ready held low for 20 cycles on word 2 -> rd_data stable and no PSEL activity during the stall. Sequence completes normally.
- Status bit5 never set, POLL_TMO=15 -> 16 reads of 0x08, then CS_OFF write; done and err pulse in the same cycle; zero rd_valid.
- PREADY inserts 3 wait states on every transfer -> the same address/data sequence as scenario 1, with PSEL/PENABLE held for the wait states.
- PRESETn asserted mid-POP -> next cycle PSEL=0, req_ready=1, rd_valid=0. A fresh request after release completes correctly.
